// File: rtl/i_parcel_issue.sv
// i_parcel_issue: owns the parcel counter P, takes parcels from the instruction
// buffers and assembles 1- or 2-parcel instructions (CIP/LIP) for issue.
// Handles jump redirects and consumer back-pressure. There is no fetch-ahead:
// a new opcode parcel is taken only after the held instruction has issued.
// Optional feature: define IPAR_ICOUNT_EN to build the 32-bit issued-instruction
// counter; otherwise o_icount is tied to zero.
module i_parcel_issue #(
    parameter int unsigned    P_W      = 24,
    parameter int unsigned    PARCEL_W = 16,
    parameter logic [P_W-1:0] RESET_P  = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic [P_W-1:0]      o_p_addr,
    input  logic [PARCEL_W-1:0] i_nip,
    input  logic                i_nip_vld,
    output logic [PARCEL_W-1:0] o_cip,
    output logic [PARCEL_W-1:0] o_lip,
    output logic                o_two_par,
    output logic [P_W-1:0]      o_cip_p,
    output logic                o_cip_vld,
    input  logic                i_issue,
    input  logic                i_jmp,
    input  logic [P_W-1:0]      i_jmp_addr,
    output logic [31:0]         o_icount
);

    typedef enum logic [1:0] {StFetch1, StFetch2, StHold} state_e;

    localparam logic [P_W-1:0] POne = P_W'(1);

    state_e                state_q, state_d;
    logic [P_W-1:0]        p_q, p_d;
    logic [PARCEL_W-1:0]   cip_q, cip_d;
    logic [PARCEL_W-1:0]   lip_q, lip_d;
    logic [P_W-1:0]        cip_p_q, cip_p_d;
    logic                  two_q, two_d;
    logic                  vld_q, vld_d;

    // Opcode field gh = parcel[15:9]; octal 006-021, 040-041, 100-137 carry a lower parcel.
    function automatic logic is_two_parcel(input logic [6:0] gh);
        return ((gh >= 7'd6) && (gh <= 7'd17)) || (gh == 7'd32) || (gh == 7'd33) ||
               ((gh >= 7'd64) && (gh <= 7'd95));
    endfunction

    // Next-state: parcel capture, P advance, issue handshake, jump redirect.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        cip_d   = cip_q;
        lip_d   = lip_q;
        cip_p_d = cip_p_q;
        two_d   = two_q;
        vld_d   = vld_q;
        unique case (state_q)
            StFetch1: begin
                if (i_nip_vld) begin
                    cip_d   = i_nip;
                    cip_p_d = p_q;
                    p_d     = p_q + POne;
                    lip_d   = '0;
                    two_d   = is_two_parcel(i_nip[PARCEL_W-1 -: 7]);
                    if (is_two_parcel(i_nip[PARCEL_W-1 -: 7])) begin
                        state_d = StFetch2;
                    end else begin
                        vld_d   = 1'b1;
                        state_d = StHold;
                    end
                end
            end
            StFetch2: begin
                if (i_nip_vld) begin
                    lip_d   = i_nip;
                    p_d     = p_q + POne;
                    vld_d   = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (i_issue) begin
                    vld_d   = 1'b0;
                    state_d = StFetch1;
                end
            end
            default: state_d = StFetch1;
        endcase
        // Redirect wins: any parcel arriving this cycle is discarded.
        if (i_jmp) begin
            p_d     = i_jmp_addr;
            cip_d   = cip_q;
            cip_p_d = cip_p_q;
            two_d   = two_q;
            lip_d   = '0;
            vld_d   = 1'b0;
            state_d = StFetch1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StFetch1;
            p_q     <= RESET_P;
            cip_q   <= '0;
            lip_q   <= '0;
            cip_p_q <= '0;
            two_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            cip_q   <= cip_d;
            lip_q   <= lip_d;
            cip_p_q <= cip_p_d;
            two_q   <= two_d;
            vld_q   <= vld_d;
        end
    end

`ifdef IPAR_ICOUNT_EN
    logic [31:0] icount_q;

    // Count accepted issues, including an issue coincident with a jump.
    always_ff @(posedge clk) begin
        if (!rst) begin
            icount_q <= '0;
        end else if ((state_q == StHold) && i_issue) begin
            icount_q <= icount_q + 32'd1;
        end
    end

    assign o_icount = icount_q;
`else
    assign o_icount = 32'h0;
`endif

    assign o_p_addr  = p_q;
    assign o_cip     = cip_q;
    assign o_lip     = lip_q;
    assign o_cip_p   = cip_p_q;
    assign o_two_par = two_q;
    assign o_cip_vld = vld_q;

endmodule

// File: tb/tb_i_parcel_issue.sv
// Directed self-checking bench for i_parcel_issue.
module tb_i_parcel_issue;

`ifdef IPAR_ICOUNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] o_p_addr;
    logic [15:0] i_nip;
    logic        i_nip_vld;
    logic [15:0] o_cip;
    logic [15:0] o_lip;
    logic        o_two_par;
    logic [23:0] o_cip_p;
    logic        o_cip_vld;
    logic        i_issue;
    logic        i_jmp;
    logic [23:0] i_jmp_addr;
    logic [31:0] o_icount;

    int n_chk  = 0;
    int n_fail = 0;
    int n_iss  = 0;   // issues the model expects to have been counted

    always #5 clk = ~clk;

    i_parcel_issue dut (
        .clk        (clk),
        .rst        (rst),
        .o_p_addr   (o_p_addr),
        .i_nip      (i_nip),
        .i_nip_vld  (i_nip_vld),
        .o_cip      (o_cip),
        .o_lip      (o_lip),
        .o_two_par  (o_two_par),
        .o_cip_p    (o_cip_p),
        .o_cip_vld  (o_cip_vld),
        .i_issue    (i_issue),
        .i_jmp      (i_jmp),
        .i_jmp_addr (i_jmp_addr),
        .o_icount   (o_icount)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; i_nip = 16'h0; i_nip_vld = 1'b0; i_issue = 1'b0;
        i_jmp = 1'b0; i_jmp_addr = 24'h0;
        tick(); tick();
        rst = 1'b1;
        n_chk++; if (o_p_addr !== 24'h0) begin n_fail++; $display("FAIL reset_p got %h want 000000", o_p_addr); end
        n_chk++; if (o_cip_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b want 0", o_cip_vld); end
        n_chk++; if (o_cip !== 16'h0 || o_lip !== 16'h0) begin n_fail++; $display("FAIL reset_cip_lip got %h/%h want 0/0", o_cip, o_lip); end
        n_chk++; if (o_two_par !== 1'b0 || o_cip_p !== 24'h0) begin n_fail++; $display("FAIL reset_two_cipp got %b/%h want 0/0", o_two_par, o_cip_p); end
        n_chk++; if (o_icount !== 32'h0) begin n_fail++; $display("FAIL reset_icount got %h want 0", o_icount); end
        // Issue with nothing held must be ignored.
        i_issue = 1'b1; tick(); i_issue = 1'b0;
        n_chk++; if (o_icount !== 32'h0 || o_cip_vld !== 1'b0) begin n_fail++; $display("FAIL idle_issue icount %h vld %b want 0/0", o_icount, o_cip_vld); end
    endtask

    task automatic test_single();
        i_nip_vld = 1'b1; i_nip = 16'o005000;
        tick();
        n_chk++; if (o_cip_vld !== 1'b1 || o_cip !== 16'o005000 || o_cip_p !== 24'd0) begin n_fail++; $display("FAIL single1 vld %b cip %o cip_p %h want 1/005000/0", o_cip_vld, o_cip, o_cip_p); end
        n_chk++; if (o_two_par !== 1'b0 || o_lip !== 16'h0 || o_p_addr !== 24'd1) begin n_fail++; $display("FAIL single1_aux two %b lip %h p %h want 0/0/1", o_two_par, o_lip, o_p_addr); end
        i_nip = 16'o001000; i_issue = 1'b1;
        tick(); i_issue = 1'b0; n_iss++;
        n_chk++; if (o_cip_vld !== 1'b0 || o_p_addr !== 24'd1) begin n_fail++; $display("FAIL issue1 vld %b p %h want 0/1", o_cip_vld, o_p_addr); end
        tick();
        n_chk++; if (o_cip_vld !== 1'b1 || o_cip !== 16'o001000 || o_cip_p !== 24'd1 || o_p_addr !== 24'd2) begin n_fail++; $display("FAIL single2 vld %b cip %o cip_p %h p %h want 1/001000/1/2", o_cip_vld, o_cip, o_cip_p, o_p_addr); end
        i_issue = 1'b1; i_nip_vld = 1'b0;
        tick(); i_issue = 1'b0; n_iss++;
        n_chk++; if (o_icount !== (CntEn ? 32'(n_iss) : 32'h0)) begin n_fail++; $display("FAIL icount_single got %0d want %0d", o_icount, CntEn ? n_iss : 0); end
    endtask

    task automatic test_two_parcel();
        i_jmp = 1'b1; i_jmp_addr = 24'd4; tick(); i_jmp = 1'b0;
        i_nip_vld = 1'b1; i_nip = 16'o020100;
        tick();
        n_chk++; if (o_cip_vld !== 1'b0 || o_p_addr !== 24'd5 || o_cip_p !== 24'd4) begin n_fail++; $display("FAIL two_first vld %b p %h cip_p %h want 0/5/4", o_cip_vld, o_p_addr, o_cip_p); end
        i_nip = 16'h1234;
        tick();
        n_chk++; if (o_cip_vld !== 1'b1 || o_two_par !== 1'b1 || o_lip !== 16'h1234 || o_cip !== 16'o020100 || o_p_addr !== 24'd6) begin n_fail++; $display("FAIL two_done vld %b two %b lip %h cip %o p %h want 1/1/1234/020100/6", o_cip_vld, o_two_par, o_lip, o_cip, o_p_addr); end
        i_issue = 1'b1; i_nip_vld = 1'b0;
        tick(); i_issue = 1'b0; n_iss++;
        n_chk++; if (o_cip_vld !== 1'b0 || o_icount !== (CntEn ? 32'(n_iss) : 32'h0)) begin n_fail++; $display("FAIL two_issue vld %b icount %0d want 0/%0d", o_cip_vld, o_icount, CntEn ? n_iss : 0); end
    endtask

    task automatic test_stall();
        i_nip_vld = 1'b1; i_nip = 16'o040000;
        tick();
        i_nip_vld = 1'b0; i_nip = 16'hdead;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++; if (o_p_addr !== 24'd7 || o_cip !== 16'o040000 || o_cip_vld !== 1'b0) begin n_fail++; $display("FAIL stall[%0d] p %h cip %o vld %b want 7/040000/0", i, o_p_addr, o_cip, o_cip_vld); end
        end
        i_nip_vld = 1'b1; i_nip = 16'h5678;
        tick();
        n_chk++; if (o_cip_vld !== 1'b1 || o_lip !== 16'h5678 || o_p_addr !== 24'd8 || o_two_par !== 1'b1) begin n_fail++; $display("FAIL stall_end vld %b lip %h p %h two %b want 1/5678/8/1", o_cip_vld, o_lip, o_p_addr, o_two_par); end
    endtask

    task automatic test_hold();
        i_nip = 16'h0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_chk++; if (o_cip !== 16'o040000 || o_lip !== 16'h5678 || o_p_addr !== 24'd8 || o_cip_vld !== 1'b1) begin n_fail++; $display("FAIL hold[%0d] cip %o lip %h p %h vld %b want 040000/5678/8/1", i, o_cip, o_lip, o_p_addr, o_cip_vld); end
        end
        i_issue = 1'b1; i_nip_vld = 1'b0;
        tick(); i_issue = 1'b0; n_iss++;
        n_chk++; if (o_icount !== (CntEn ? 32'(n_iss) : 32'h0)) begin n_fail++; $display("FAIL hold_issue icount %0d want %0d", o_icount, CntEn ? n_iss : 0); end
    endtask

    task automatic test_jump();
        i_nip_vld = 1'b1; i_nip = 16'o100000;
        tick();
        n_chk++; if (o_p_addr !== 24'd9 || o_cip_vld !== 1'b0) begin n_fail++; $display("FAIL jmp_pre p %h vld %b want 9/0", o_p_addr, o_cip_vld); end
        i_jmp = 1'b1; i_jmp_addr = 24'h000100; i_nip = 16'hbeef;
        tick(); i_jmp = 1'b0;
        n_chk++; if (o_p_addr !== 24'h000100 || o_cip_vld !== 1'b0 || o_lip !== 16'h0) begin n_fail++; $display("FAIL jmp_f2 p %h vld %b lip %h want 000100/0/0", o_p_addr, o_cip_vld, o_lip); end
        i_nip = 16'o022000;   // gh=022: just past the 020-021 range, single parcel
        tick();
        n_chk++; if (o_cip_vld !== 1'b1 || o_cip_p !== 24'h000100 || o_p_addr !== 24'h000101 || o_two_par !== 1'b0) begin n_fail++; $display("FAIL jmp_next vld %b cip_p %h p %h two %b want 1/000100/000101/0", o_cip_vld, o_cip_p, o_p_addr, o_two_par); end
        i_jmp = 1'b1; i_jmp_addr = 24'h000200; i_issue = 1'b1;
        tick(); i_jmp = 1'b0; i_issue = 1'b0; n_iss++;
        n_chk++; if (o_icount !== (CntEn ? 32'(n_iss) : 32'h0) || o_cip_vld !== 1'b0 || o_p_addr !== 24'h000200) begin n_fail++; $display("FAIL jmp_issue icount %0d vld %b p %h want %0d/0/000200", o_icount, o_cip_vld, o_p_addr, CntEn ? n_iss : 0); end
    endtask

    task automatic test_wrap_reset();
        i_nip_vld = 1'b0;
        i_jmp = 1'b1; i_jmp_addr = 24'hFFFFFF; tick(); i_jmp = 1'b0;
        i_nip_vld = 1'b1; i_nip = 16'o006000;
        tick();
        n_chk++; if (o_p_addr !== 24'h0 || o_cip_p !== 24'hFFFFFF || o_cip_vld !== 1'b0) begin n_fail++; $display("FAIL wrap_first p %h cip_p %h vld %b want 000000/ffffff/0", o_p_addr, o_cip_p, o_cip_vld); end
        i_nip = 16'hABCD;
        tick();
        n_chk++; if (o_lip !== 16'hABCD || o_p_addr !== 24'd1 || o_cip_vld !== 1'b1 || o_two_par !== 1'b1) begin n_fail++; $display("FAIL wrap_done lip %h p %h vld %b two %b want abcd/1/1/1", o_lip, o_p_addr, o_cip_vld, o_two_par); end
        rst = 1'b0; i_issue = 1'b1; i_jmp = 1'b1; i_jmp_addr = 24'h123456;
        tick();
        rst = 1'b1; i_issue = 1'b0; i_jmp = 1'b0; i_nip_vld = 1'b0;
        n_chk++; if (o_p_addr !== 24'h0 || o_cip_vld !== 1'b0 || o_cip !== 16'h0 || o_lip !== 16'h0) begin n_fail++; $display("FAIL midrst p %h vld %b cip %h lip %h want 0/0/0/0", o_p_addr, o_cip_vld, o_cip, o_lip); end
        n_chk++; if (o_two_par !== 1'b0 || o_cip_p !== 24'h0 || o_icount !== 32'h0) begin n_fail++; $display("FAIL midrst_aux two %b cip_p %h icount %h want 0/0/0", o_two_par, o_cip_p, o_icount); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_parcel();
        test_stall();
        test_hold();
        test_jump();
        test_wrap_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
